t01_game_input_ctrl: RTL

//  Parametrised successor to the top-level mode/input steering of the Tetris build. Debounces N raw

---
 rtl/t01_pkg.sv | 28 ++
 rtl/t01_debounce_n.sv | 52 +++++
 rtl/t01_game_input_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/t01_pkg.sv
// t01_pkg: shared types and constants
// for the game input controller.
package t01_pkg;

  typedef enum logic [1:0] {
    MODE_MENU  = 2'd0,
    MODE_HUMAN = 2'd1,
    MODE_AI    = 2'd2,
    MODE_PAUSE = 2'd3
  } mode_e;

  localparam logic [3:0] GS_IDLE  = 4'd0;
  localparam logic [3:0] GS_OVER  = 4'd8;
  localparam logic [3:0] GS_READY = 4'd9;

  localparam int CH_RIGHT = 0;
  localparam int CH_LEFT  = 1;
  localparam int CH_ROT_R = 2;
  localparam int CH_ROT_L = 3;
  localparam int CH_SPEED = 4;

  // aux bits sit above the move channels
  localparam int AUX_START_H  = 0;
  localparam int AUX_START_AI = 1;
  localparam int AUX_PAUSE    = 2;
  localparam int AUX_N        = 3;

endpackage

// File: rtl/t01_debounce_n.sv
// t01_debounce_n: two-flop synchroniser and
// per-bit debounce for WIDTH raw inputs.
module t01_debounce_n #(
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];

  // bring raw buttons into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // flip a level only after a full run of
  // disagreement; any agreement restarts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] ==
                     CW'(DEBOUNCE_CYC - 1)) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/t01_game_input_ctrl.sv
// t01_game_input_ctrl: mode FSM, button
// auto-repeat and AI command port.
module t01_game_input_ctrl
  import t01_pkg::*;
#(
  parameter int NUM_BTN      = 5,
  parameter int SPEED_IDX    = CH_SPEED,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00011,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int DAS_DELAY    = 4000000,
  parameter int DAS_RATE     = 1250000,
  parameter int AI_GAP       = 2500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pb_raw,
  input  logic               start_human,
  input  logic               start_ai,
  input  logic               pause_btn,
  input  logic [3:0]         gamestate,
  input  logic [NUM_BTN-1:0] ai_cmd,
  input  logic               ai_cmd_valid,
  output logic               ai_cmd_ready,
  output logic [NUM_BTN-1:0] cmd_o,
  output logic               speed_o,
  output logic [1:0]         mode_o
);

  localparam int NB = NUM_BTN + AUX_N;
  localparam int DAS_MAX =
    (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
  localparam int DW = $clog2(DAS_MAX + 1);
  localparam int GW = $clog2(AI_GAP + 1);
  localparam logic [NUM_BTN-1:0] SPD_MASK =
    NUM_BTN'(1) << SPEED_IDX;

  logic [NB-1:0]      raw_all;
  logic [NB-1:0]      db;
  logic [NB-1:0]      db_q;
  logic               sh_edge;
  logic               ai_edge;
  logic               pause_edge;
  mode_e              mode;
  mode_e              mode_nx;
  mode_e              pmode;
  logic               go;
  logic               mode_chg;
  logic               ai_acc;
  logic [NUM_BTN-1:0] armed;
  logic [NUM_BTN-1:0] edge_fire;
  logic [NUM_BTN-1:0] rep_fire;
  logic [NUM_BTN-1:0] das_first;
  logic [DW-1:0]      das_cnt [NUM_BTN];
  logic [GW-1:0]      gap;
  logic [GW-1:0]      gap_nx;

  assign raw_all =
    {pause_btn, start_ai, start_human, pb_raw};

  t01_debounce_n #(
    .WIDTH        (NB),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_all),
    .level (db)
  );

  assign sh_edge =
    db[NUM_BTN + AUX_START_H] &
    ~db_q[NUM_BTN + AUX_START_H];
  assign ai_edge =
    db[NUM_BTN + AUX_START_AI] &
    ~db_q[NUM_BTN + AUX_START_AI];
  assign pause_edge =
    db[NUM_BTN + AUX_PAUSE] &
    ~db_q[NUM_BTN + AUX_PAUSE];

  assign mode_chg = (mode_nx != mode);
  // pulses only while staying in human play
  assign go = (mode == MODE_HUMAN) &&
              (mode_nx == MODE_HUMAN);
  assign ai_acc = (mode == MODE_AI) &&
                  (mode_nx == MODE_AI) &&
                  ai_cmd_valid && ai_cmd_ready;
  assign mode_o = mode;

  // next mode, in priority order
  always_comb begin
    mode_nx = mode;
    unique case (mode)
      MODE_MENU: begin
        if (gamestate == GS_IDLE ||
            gamestate == GS_READY) begin
          if (ai_edge)
            mode_nx = MODE_AI;
          else if (sh_edge)
            mode_nx = MODE_HUMAN;
        end
      end
      MODE_HUMAN, MODE_AI: begin
        if (gamestate == GS_OVER)
          mode_nx = MODE_MENU;
        else if (pause_edge)
          mode_nx = MODE_PAUSE;
      end
      MODE_PAUSE: begin
        if (gamestate == GS_OVER)
          mode_nx = MODE_MENU;
        else if (pause_edge)
          mode_nx = pmode;
      end
    endcase
  end

  // edge and repeat pulse requests
  always_comb begin
    edge_fire = '0;
    rep_fire  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (i != SPEED_IDX && go && db[i]) begin
        edge_fire[i] = armed[i] & ~db_q[i];
        if (REPEAT_MASK[i] &&
            das_cnt[i] != '0) begin
          rep_fire[i] = das_first[i] ?
            (das_cnt[i] == DW'(DAS_DELAY)) :
            (das_cnt[i] == DW'(DAS_RATE));
        end
      end
    end
  end

  // AI gap countdown, reloaded on accept
  always_comb begin
    if (ai_acc)
      gap_nx = GW'(AI_GAP);
    else if (gap != '0)
      gap_nx = gap - GW'(1);
    else
      gap_nx = '0;
  end

  // mode, pause source, arming, edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode  <= MODE_MENU;
      pmode <= MODE_HUMAN;
      armed <= '0;
      db_q  <= '0;
    end else begin
      mode <= mode_nx;
      if (mode_nx == MODE_PAUSE &&
          mode != MODE_PAUSE)
        pmode <= mode;
      armed <= mode_chg ? '0 :
               (armed | ~db[NUM_BTN-1:0]);
      db_q <= db;
    end
  end

  // auto-repeat counters: 0 idle, else age
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      das_first <= '0;
      for (int i = 0; i < NUM_BTN; i++)
        das_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!REPEAT_MASK[i] || !go || !db[i]) begin
          das_cnt[i]   <= '0;
          das_first[i] <= 1'b0;
        end else if (edge_fire[i]) begin
          das_cnt[i]   <= DW'(1);
          das_first[i] <= 1'b1;
        end else if (rep_fire[i]) begin
          das_cnt[i]   <= DW'(1);
          das_first[i] <= 1'b0;
        end else if (das_cnt[i] != '0 &&
                     das_cnt[i] != DW'(DAS_MAX)) begin
          das_cnt[i] <= das_cnt[i] + DW'(1);
        end
      end
    end
  end

  // registered command, speed and AI port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap          <= '0;
      ai_cmd_ready <= 1'b0;
      cmd_o        <= '0;
      speed_o      <= 1'b0;
    end else begin
      gap <= (mode_nx == MODE_AI) ? gap_nx : '0;
      ai_cmd_ready <= (mode_nx == MODE_AI) &&
                      (gap_nx == '0);
      cmd_o <= ai_acc ? (ai_cmd & ~SPD_MASK) :
               ((edge_fire | rep_fire) & ~SPD_MASK);
      speed_o <= (mode_nx == MODE_AI) ||
                 ((mode_nx == MODE_HUMAN) &&
                  db[SPEED_IDX]);
    end
  end

endmodule
